// File: rtl/mod_sched.sv
// -----------------------------------------------------------------------------
// mod_sched
// Two-requester scheduler that time-shares one iterative modulus unit
// (8-bit A mod 4-bit B, restoring remainder, one quotient bit per cycle).
// Only one operation is in flight at a time. When both requesters ask in the
// same IDLE cycle, the one that was not served last wins.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   reset       : synchronous, active-high reset
//   req0/a0/b0  : requester 0 request, dividend A, divisor B
//   req1/a1/b1  : requester 1 request, dividend A, divisor B
//   gnt0/gnt1   : one-cycle pulse, that requester's operands were latched
//   busy        : high whenever the FSM is not in IDLE
//   done        : one-cycle pulse, y/owner/dz are newly valid
//   y           : A mod B zero-extended (A itself when B == 0)
//   owner       : index of the requester that owns y
//   dz          : divide-by-zero flag for the current y
// -----------------------------------------------------------------------------
module mod_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic [7:0] y,
    output logic       owner,
    output logic       dz
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic        lp_r;      // last requester served
    logic        own_r;     // requester owning the operation in flight
    logic [7:0]  a_r;
    logic [3:0]  b_r;
    // Partial remainder. It is always < B <= 15 after each step, so the top bit
    // of the 5-bit working value is never needed between iterations.
    logic [3:0]  r_r;
    logic [2:0]  cnt_r;

    logic        take_s;    // a grant happens on this edge
    logic        sel_s;     // requester being granted
    logic        bit_s;
    logic [4:0]  r5_s;
    logic        ge_s;
    logic [3:0]  r_nxt_s;
    logic        fin_s;     // CALC is leaving for DONE on this edge

    logic        gnt0_s;
    logic        gnt1_s;
    logic        busy_s;
    logic        done_s;
    logic [7:0]  y_s;
    logic        owner_s;
    logic        dz_s;

    // Arbitration: only IDLE samples requests; a tie goes to the non-last-served side.
    always_comb begin
        take_s = 1'b0;
        sel_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0 && req1) begin
                take_s = 1'b1;
                sel_s  = ~lp_r;
            end else if (req0) begin
                take_s = 1'b1;
                sel_s  = 1'b0;
            end else if (req1) begin
                take_s = 1'b1;
                sel_s  = 1'b1;
            end else begin
                take_s = 1'b0;
                sel_s  = 1'b0;
            end
        end else begin
            take_s = 1'b0;
            sel_s  = 1'b0;
        end
    end

    // One restoring-remainder step, dividend bits consumed MSB first.
    always_comb begin
        bit_s = a_r[3'd7 - cnt_r];
        r5_s  = {r_r, bit_s};
        ge_s  = (r5_s >= {1'b0, b_r});
        // When r5 >= B the difference is < B, so the low 4 bits of a
        // 4-bit subtraction are exact.
        if (ge_s) begin
            r_nxt_s = r5_s[3:0] - b_r;
        end else begin
            r_nxt_s = r5_s[3:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if ((b_r == 4'd0) || (cnt_r == 3'd7)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        fin_s   = (state_r == ST_CALC) && (state_s == ST_DONE);
        gnt0_s  = take_s && !sel_s;
        gnt1_s  = take_s && sel_s;
        busy_s  = (state_s != ST_IDLE);
        done_s  = fin_s;
        y_s     = y;
        owner_s = owner;
        dz_s    = dz;
        if (fin_s && (b_r == 4'd0)) begin
            y_s     = a_r;
            owner_s = own_r;
            dz_s    = 1'b1;
        end else if (fin_s) begin
            y_s     = {4'b0000, r_nxt_s};
            owner_s = own_r;
            dz_s    = 1'b0;
        end else begin
            y_s     = y;
            owner_s = owner;
            dz_s    = dz;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, arbitration pointer and iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            lp_r  <= 1'b1;
            own_r <= 1'b0;
            a_r   <= 8'h00;
            b_r   <= 4'h0;
            r_r   <= 4'h0;
            cnt_r <= 3'd0;
        end else if (take_s) begin
            lp_r  <= sel_s;
            own_r <= sel_s;
            a_r   <= sel_s ? a1 : a0;
            b_r   <= sel_s ? b1 : b0;
            r_r   <= 4'h0;
            cnt_r <= 3'd0;
        end else if ((state_r == ST_CALC) && (b_r != 4'd0)) begin
            r_r   <= r_nxt_s;
            cnt_r <= cnt_r + 3'd1;
        end else begin
            r_r   <= r_r;
            cnt_r <= cnt_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= 8'h00;
            owner <= 1'b0;
            dz    <= 1'b0;
        end else begin
            gnt0  <= gnt0_s;
            gnt1  <= gnt1_s;
            busy  <= busy_s;
            done  <= done_s;
            y     <= y_s;
            owner <= owner_s;
            dz    <= dz_s;
        end
    end

endmodule

// File: tb/tb_mod_sched.sv
// -----------------------------------------------------------------------------
// tb_mod_sched
// Directed stimulus with hand-computed results. Stimulus pushes the expected
// grant owner and the expected done result into queues; a monitor sampling
// 2 time units after each rising edge pops and compares whenever gnt or done
// is presented, and checks that y/owner/dz hold between dones.
// -----------------------------------------------------------------------------
module tb_mod_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] a0, a1;
    logic [3:0] b0, b1;
    logic       gnt0, gnt1, busy, done, owner, dz;
    logic [7:0] y;

    typedef struct {
        logic       own;
        logic       dz;
        logic [7:0] y;
        int         lat;
    } res_t;

    res_t rq[$];
    logic gq[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_gnt    = 0;
    int n_done   = 0;
    int gnt_cyc  = 0;
    int done_cyc = 0;

    mod_sched dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .owner (owner),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    // Monitor / scoreboard.
    initial begin
        res_t       e;
        logic       g;
        logic [7:0] hold_y;
        logic       hold_own;
        logic       hold_dz;
        hold_y   = 8'h00;
        hold_own = 1'b0;
        hold_dz  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (reset) begin
                checks++;
                if ({gnt0, gnt1, busy, done, y, owner, dz} !== 14'd0) begin
                    errors++;
                    $display("FAIL reset_outputs got gnt0=%b gnt1=%b busy=%b done=%b y=%h owner=%b dz=%b want all 0",
                             gnt0, gnt1, busy, done, y, owner, dz);
                end
                hold_y   = 8'h00;
                hold_own = 1'b0;
                hold_dz  = 1'b0;
            end else begin
                if (gnt0 && gnt1) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_overlap got gnt0=1 gnt1=1 want at most one");
                end
                if (gnt0 || gnt1) begin
                    checks++;
                    g = gnt1;
                    if (gq.size() == 0) begin
                        errors++;
                        $display("FAIL gnt_unexpected got gnt%0d want none", g);
                    end else if (gq.pop_front() !== g) begin
                        errors++;
                        $display("FAIL gnt_order got gnt%0d want the other requester", g);
                    end
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL gnt_busy got %b want 1", busy);
                    end
                    gnt_cyc = cyc;
                    n_gnt++;
                end
                if (done === 1'b1) begin
                    checks++;
                    if (rq.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected got done y=%h owner=%b want no done", y, owner);
                    end else begin
                        e = rq.pop_front();
                        if (y !== e.y || owner !== e.own || dz !== e.dz) begin
                            errors++;
                            $display("FAIL done_result got y=%h owner=%b dz=%b want y=%h owner=%b dz=%b",
                                     y, owner, dz, e.y, e.own, e.dz);
                        end
                        checks++;
                        if (cyc - gnt_cyc != e.lat) begin
                            errors++;
                            $display("FAIL done_latency got %0d want %0d", cyc - gnt_cyc, e.lat);
                        end
                    end
                    hold_y   = y;
                    hold_own = owner;
                    hold_dz  = dz;
                    done_cyc = cyc;
                    n_done++;
                end else begin
                    checks++;
                    if (y !== hold_y || owner !== hold_own || dz !== hold_dz) begin
                        errors++;
                        $display("FAIL result_hold got y=%h owner=%b dz=%b want y=%h owner=%b dz=%b",
                                 y, owner, dz, hold_y, hold_own, hold_dz);
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input int target);
        int k;
        k = 0;
        while (n_gnt < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (n_gnt < target) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout got %0d grants want %0d", n_gnt, target);
        end
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (n_done < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got %0d dones want %0d", n_done, target);
        end
    endtask

    task automatic push_exp(input logic who, input logic edz, input logic [7:0] ey, input int lat);
        res_t e;
        e.own = who;
        e.dz  = edz;
        e.y   = ey;
        e.lat = lat;
        rq.push_back(e);
    endtask

    // One request from one requester; expected result supplied by the caller.
    task automatic single(input logic who, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] ey, input logic edz, input int lat);
        int g0;
        int d0;
        g0 = n_gnt;
        d0 = n_done;
        gq.push_back(who);
        push_exp(who, edz, ey, lat);
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
        wait_gnt(g0 + 1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(d0 + 1);
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int g0;
        int d0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'h00; b0 = 4'h0; a1 = 8'h00; b1 = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, busy, done, y, owner, dz} !== 14'd0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b y=%h want all 0", busy, done, y);
        end

        // Basic and boundary operands.
        single(1'b0, 8'd200, 4'd7,  8'd4,   1'b0, 8);
        single(1'b1, 8'hAB,  4'd0,  8'hAB,  1'b1, 1);
        single(1'b0, 8'd77,  4'd1,  8'd0,   1'b0, 8);
        single(1'b1, 8'd5,   4'd13, 8'd5,   1'b0, 8);
        single(1'b0, 8'd255, 4'd14, 8'd3,   1'b0, 8);

        // Reset in the 4th CALC cycle aborts the operation (y was 3 before).
        g0 = n_gnt;
        d0 = n_done;
        gq.push_back(1'b0);
        req0 = 1'b1; a0 = 8'd200; b0 = 4'd7;
        wait_gnt(g0 + 1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || y !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got busy=%b y=%h done=%b want 0 00 0", busy, y, done);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (n_done != d0) begin
            errors++;
            $display("FAIL abort_no_done got %0d dones want %0d", n_done, d0);
        end
        single(1'b1, 8'd100, 4'd9, 8'd1, 1'b0, 8);

        // Simultaneous requests after reset, req1 held.
        do_reset;
        g0 = n_gnt;
        d0 = n_done;
        gq.push_back(1'b0);
        gq.push_back(1'b1);
        push_exp(1'b0, 1'b0, 8'd1, 8);
        push_exp(1'b1, 1'b0, 8'd0, 8);
        req0 = 1'b1; a0 = 8'd100; b0 = 4'd9;
        req1 = 1'b1; a1 = 8'd255; b1 = 4'd15;
        wait_gnt(g0 + 1);
        req0 = 1'b0;
        wait_gnt(g0 + 2);
        req1 = 1'b0;
        checks++;
        if (gnt_cyc - done_cyc != 2) begin
            errors++;
            $display("FAIL tie_second_gnt got %0d cycles after done want 2", gnt_cyc - done_cyc);
        end
        wait_done(d0 + 2);
        @(negedge clk);

        // Both requesters held: grants alternate 0,1,0,1.
        do_reset;
        g0 = n_gnt;
        d0 = n_done;
        for (int i = 0; i < 4; i++) begin
            gq.push_back(i[0]);
            if (i[0]) begin
                push_exp(1'b1, 1'b0, 8'd1, 8);
            end else begin
                push_exp(1'b0, 1'b0, 8'd4, 8);
            end
        end
        req0 = 1'b1; a0 = 8'd200; b0 = 4'd7;
        req1 = 1'b1; a1 = 8'd100; b1 = 4'd9;
        wait_gnt(g0 + 4);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(d0 + 4);
        repeat (3) @(negedge clk);

        checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got grants=%0d results=%0d want 0 0", gq.size(), rq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_sched.md
MOD_SCHED -- requirements
Module: mod_sched

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port `req0`, input, 1 bit: requester 0 asks for a modulus operation.
REQ-004 The block SHALL have port `a0`, input, 8 bits: requester 0 dividend A.
REQ-005 The block SHALL have port `b0`, input, 4 bits: requester 0 divisor B.
REQ-006 The block SHALL have ports `req1` (1 bit), `a1` (8 bits) and `b1` (4 bits), inputs: the same meanings for requester 1.
REQ-007 The block SHALL have ports `gnt0` and `gnt1`, outputs, 1 bit each: one-cycle pulse meaning the requester's operands were latched.
REQ-008 The block SHALL have port `busy`, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-009 The block SHALL have port `done`, output, 1 bit: one-cycle pulse meaning y, owner and dz are newly valid.
REQ-010 The block SHALL have port `y`, output, 8 bits: result A mod B, zero-extended.
REQ-011 The block SHALL have port `owner`, output, 1 bit: index of the requester that owns y.
REQ-012 The block SHALL have port `dz`, output, 1 bit: divide-by-zero flag for the current y.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE; the reset state SHALL be IDLE.
REQ-014 The block SHALL time-share one iterative modulus datapath between two requesters; at most one operation SHALL be in flight at a time.
REQ-015 On a rising edge in IDLE with exactly one req high, the block SHALL latch that requester's a and b, record owner, update the last-served pointer lp and go to CALC.
REQ-016 On a rising edge in IDLE with both req high, the block SHALL grant the requester not equal to lp; reset SHALL set lp=1, so requester 0 wins the first tie.
REQ-017 In IDLE with no req high, the state SHALL stay IDLE and no grant SHALL be issued.
REQ-018 gnt0/gnt1 SHALL be registered and high for exactly the first cycle after the granting edge; at most one of them SHALL be high in any cycle.
REQ-019 A requester SHALL drop req in the cycle it sees its gnt; req is sampled only in IDLE, so a req still high during CALC or DONE SHALL be ignored.
REQ-020 A req still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-021 In CALC with latched B != 0, the block SHALL perform a restoring remainder over 8 edges, i = 0..7, MSB first.
REQ-022 Each CALC iteration SHALL compute r5 = {r[3:0], A[7-i]}, with r a 5-bit register cleared on grant; if r5 >= {1'b0, B}, then r = r5 - B, otherwise r = r5.
REQ-023 An internal 3-bit iteration counter SHALL wrap 7 -> 0; the edge on which counter = 7 SHALL move the FSM to DONE.
REQ-024 On the transition to DONE, the block SHALL load y = {4'b0, r[3:0]} and dz = 0.
REQ-025 If latched B == 0, CALC SHALL be bypassed: the first edge after the grant SHALL move the FSM to DONE with y = A and dz = 1.
REQ-026 Latency SHALL be as follows: done is high in the 8th cycle after the gnt cycle for B != 0, and in the cycle immediately after the gnt cycle for B == 0.
REQ-027 done SHALL be high only in state DONE, for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-028 y, owner and dz SHALL hold their values until the next done.
REQ-029 busy SHALL be low only in IDLE.
REQ-030 The minimum request-to-request period for back-to-back operations SHALL be 10 cycles for B != 0.
REQ-031 If both requesters hold req continuously, grants SHALL alternate 0, 1, 0, 1, ....

Reset
REQ-032 When reset is high at a rising edge, the block SHALL set state = IDLE, lp = 1, r = 0, counter = 0, gnt0 = gnt1 = 0, done = 0, busy = 0, y = 8'h00, owner = 0 and dz = 0.
REQ-033 Reset SHALL take priority over all other activity, including during CALC or DONE.
REQ-034 An operation aborted by reset SHALL never produce done, and its requester SHALL not receive a late grant or result.

Verification
REQ-035 The bench SHALL cover: req0 with a0 = 200, b0 = 7 -> gnt0 pulse, done 8 cycles later with y = 4, owner = 0, dz = 0.
REQ-036 The bench SHALL cover: req0 (a0 = 100, b0 = 9) and req1 (a1 = 255, b1 = 15) raised together after reset, req1 held -> first done y = 1, owner = 0; gnt1 issued in the IDLE cycle after that done; second done y = 0, owner = 1.
REQ-037 The bench SHALL cover: req1 with a1 = 8'hAB, b1 = 0 -> done in the cycle after gnt1, with y = 8'hAB, dz = 1, owner = 1.
REQ-038 The bench SHALL cover: boundary operands a = 77, b = 1 -> y = 0; a = 5, b = 13 -> y = 5; a = 255, b = 14 -> y = 3.
REQ-039 The bench SHALL cover: reset asserted on the 4th CALC cycle -> next cycle busy = 0, y = 0, and no done; a following req1 SHALL be granted normally.
REQ-040 The bench SHALL cover: both req held high for 40 cycles -> grant order 0, 1, 0, 1, gnt0/gnt1 never high together, and each done's owner matching its grant.
